// File: rtl/cache_mem_arbiter_if.sv
// Request, response and backing-memory signals shared between the cache
// requesters, the arbiter and the single-port data memory.
interface cache_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_wb;
    logic [31:0] d_wb_addr;
    logic [31:0] d_wb_data;
    logic [31:0] d_addr;
    logic        d_ready;
    logic [31:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wb, d_wb_addr, d_wb_data, d_addr, mem_rdata,
        output i_ready, i_rdata, d_ready, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wb, d_wb_addr, d_wb_data, d_addr, mem_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer for the backing data memory
// shared by the I-cache refill path and the D-cache refill/eviction path.
module cache_mem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_mem_arbiter_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, I_RD, D_WB, D_RD, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        cnt_done;
    logic        grant_i, grant_d;
    logic        last_d;
    logic        sel_d;
    logic [31:0] i_addr_q, d_addr_q, wb_addr_q, wb_data_q;
    logic [31:0] i_rdata_q, d_rdata_q;

    // On a tie the side that lost the previous grant wins.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        cnt_done  = (cnt == 4'(MEM_LAT - 1));
        case (state)
            IDLE: begin
                cnt_nxt = 4'd0;
                if (bus.i_req && bus.d_req) begin
                    grant_d = ~last_d;
                    grant_i = last_d;
                end else begin
                    grant_d = bus.d_req;
                    grant_i = bus.i_req;
                end
                if (grant_d)
                    state_nxt = bus.d_wb ? D_WB : D_RD;
                else if (grant_i)
                    state_nxt = I_RD;
            end
            I_RD, D_RD: begin
                if (cnt_done) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            D_WB: begin
                if (cnt_done) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = D_RD;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            last_d <= 1'b0;
            sel_d  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (grant_i || grant_d) begin
                last_d <= grant_d;
                sel_d  <= grant_d;
            end
        end
    end

    // Request fields are frozen at grant so requesters may change them freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant_i)
                i_addr_q <= bus.i_addr;
            if (grant_d) begin
                d_addr_q  <= bus.d_addr;
                wb_addr_q <= bus.d_wb_addr;
                wb_data_q <= bus.d_wb_data;
            end
            if (state == I_RD && cnt_done)
                i_rdata_q <= bus.mem_rdata;
            if (state == D_RD && cnt_done)
                d_rdata_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_ready   = 1'b0;
        bus.d_ready   = 1'b0;
        case (state)
            I_RD: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = i_addr_q;
            end
            D_RD: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = d_addr_q;
            end
            D_WB: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = wb_addr_q;
                bus.mem_wdata = wb_data_q;
            end
            RESP: begin
                bus.i_ready = ~sel_d;
                bus.d_ready = sel_d;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state != IDLE);
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scoreboard bench for cache_mem_arbiter: MEM_LAT=2 main instance plus
// MEM_LAT=1 and MEM_LAT=4 instances for access-window and capture timing.
module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_mem_arbiter_if bus2();
    cache_mem_arbiter_if bus1();
    cache_mem_arbiter_if bus4();

    cache_mem_arbiter #(.MEM_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    cache_mem_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    cache_mem_arbiter #(.MEM_LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic        side;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic        ovr_en;
    logic [31:0] ovr_val;

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model for the main instance: address-derived data unless overridden.
    assign bus2.mem_rdata = ovr_en ? ovr_val : fmem(bus2.mem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkOutput(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic applyStimulus(input logic use_i, input logic [31:0] i_addr,
                                 input logic use_d, input logic wb, input logic [31:0] wb_addr,
                                 input logic [31:0] wb_data, input logic [31:0] d_addr);
        if (use_i) begin
            bus2.i_req  = 1'b1;
            bus2.i_addr = i_addr;
        end
        if (use_d) begin
            bus2.d_req     = 1'b1;
            bus2.d_wb      = wb;
            bus2.d_wb_addr = wb_addr;
            bus2.d_wb_data = wb_data;
            bus2.d_addr    = d_addr;
        end
    endtask

    task automatic waitReady(input int budget, input int exp_lat);
        int   lat;
        logic got;
        exp_t e;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (bus2.i_ready || bus2.d_ready) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
        checkBit("ready_seen", got, 1'b1);
        if (got) begin
            checkOutput("ready_latency", 32'(lat), 32'(exp_lat));
            checkBit("ready_exclusive", bus2.i_ready & bus2.d_ready, 1'b0);
            checkBit("sb_empty_at_ready", sb.size() == 0, 1'b0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkBit("ready_side", bus2.d_ready, e.side);
                checkOutput("ready_rdata", e.side ? bus2.d_rdata : bus2.i_rdata, e.data);
            end
            if (bus2.d_ready) begin
                bus2.d_req = 1'b0;
                bus2.d_wb  = 1'b0;
            end else begin
                bus2.i_req = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus2.i_req = 1'b0; bus2.i_addr = '0; bus2.d_req = 1'b0; bus2.d_wb = 1'b0;
        bus2.d_wb_addr = '0; bus2.d_wb_data = '0; bus2.d_addr = '0;
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_wb = 1'b0;
        bus1.d_wb_addr = '0; bus1.d_wb_data = '0; bus1.d_addr = '0; bus1.mem_rdata = '0;
        bus4.i_req = 1'b0; bus4.i_addr = '0; bus4.d_req = 1'b0; bus4.d_wb = 1'b0;
        bus4.d_wb_addr = '0; bus4.d_wb_data = '0; bus4.d_addr = '0; bus4.mem_rdata = '0;
        ovr_en = 1'b0;
        ovr_val = '0;

        repeat (2) @(negedge clk);
        checkBit("rst_busy", bus2.busy, 1'b0);
        checkBit("rst_mem_en", bus2.mem_en, 1'b0);
        checkBit("rst_i_ready", bus2.i_ready, 1'b0);
        checkBit("rst_d_ready", bus2.d_ready, 1'b0);
        checkOutput("rst_i_rdata", bus2.i_rdata, 32'h0);
        checkOutput("rst_d_rdata", bus2.d_rdata, 32'h0);
        checkOutput("rst_mem_addr", bus2.mem_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkBit("idle_busy", bus2.busy, 1'b0);

        // Plain I read; address changes after grant must not leak to memory.
        ovr_en = 1'b1;
        ovr_val = 32'hDEADBEEF;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0);
        sb.push_back('{side: 1'b0, data: 32'hDEADBEEF});
        @(negedge clk);
        checkBit("t1_busy", bus2.busy, 1'b1);
        checkBit("t1_en_c1", bus2.mem_en, 1'b1);
        checkBit("t1_we_c1", bus2.mem_we, 1'b0);
        checkOutput("t1_addr_c1", bus2.mem_addr, 32'h100);
        bus2.i_addr = 32'h999;
        @(negedge clk);
        checkBit("t1_en_c2", bus2.mem_en, 1'b1);
        checkOutput("t1_addr_c2", bus2.mem_addr, 32'h100);
        waitReady(4, 1);
        checkBit("t1_en_resp", bus2.mem_en, 1'b0);
        @(negedge clk);
        checkBit("t1_busy_after", bus2.busy, 1'b0);
        checkBit("t1_ready_pulse", bus2.i_ready, 1'b0);
        checkOutput("t1_addr_idle", bus2.mem_addr, 32'h0);
        ovr_en = 1'b0;

        // D request with writeback: two write cycles then two read cycles.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h200, 32'h11, 32'h300);
        sb.push_back('{side: 1'b1, data: fmem(32'h300)});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkBit("t2_wb_en", bus2.mem_en, 1'b1);
            checkBit("t2_wb_we", bus2.mem_we, 1'b1);
            checkOutput("t2_wb_addr", bus2.mem_addr, 32'h200);
            checkOutput("t2_wb_data", bus2.mem_wdata, 32'h11);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkBit("t2_rd_en", bus2.mem_en, 1'b1);
            checkBit("t2_rd_we", bus2.mem_we, 1'b0);
            checkOutput("t2_rd_addr", bus2.mem_addr, 32'h300);
            checkOutput("t2_rd_wdata", bus2.mem_wdata, 32'h0);
        end
        waitReady(3, 1);
        @(negedge clk);
        checkBit("t2_ready_pulse", bus2.d_ready, 1'b0);
        checkOutput("t2_i_rdata_hold", bus2.i_rdata, 32'hDEADBEEF);

        // Round robin from reset; requests rise together with reset release.
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t3_d_rdata_rst", bus2.d_rdata, 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, '0, '0, 32'h500);
        sb.push_back('{side: 1'b1, data: fmem(32'h500)});
        sb.push_back('{side: 1'b0, data: fmem(32'h400)});
        waitReady(8, 3);
        waitReady(8, 4);
        @(negedge clk);
        applyStimulus(1'b1, 32'h600, 1'b1, 1'b0, '0, '0, 32'h700);
        sb.push_back('{side: 1'b1, data: fmem(32'h700)});
        sb.push_back('{side: 1'b0, data: fmem(32'h600)});
        waitReady(8, 3);
        waitReady(8, 4);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0, 32'h800);
        sb.push_back('{side: 1'b1, data: fmem(32'h800)});
        waitReady(8, 3);
        @(negedge clk);
        applyStimulus(1'b1, 32'h900, 1'b1, 1'b0, '0, '0, 32'hA00);
        sb.push_back('{side: 1'b0, data: fmem(32'h900)});
        sb.push_back('{side: 1'b1, data: fmem(32'hA00)});
        waitReady(8, 3);
        waitReady(8, 4);
        @(negedge clk);

        // Async reset in the middle of a writeback; held request restarts.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'hB00, 32'h22, 32'hC00);
        sb.push_back('{side: 1'b1, data: fmem(32'hC00)});
        @(negedge clk);
        checkBit("t4_we_before", bus2.mem_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkBit("t4_async_en", bus2.mem_en, 1'b0);
        checkBit("t4_async_we", bus2.mem_we, 1'b0);
        checkBit("t4_async_busy", bus2.busy, 1'b0);
        @(negedge clk);
        checkBit("t4_no_ready", bus2.d_ready, 1'b0);
        checkBit("t4_en_in_rst", bus2.mem_en, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkBit("t4_restart_we", bus2.mem_we, 1'b1);
        checkOutput("t4_restart_addr", bus2.mem_addr, 32'hB00);
        waitReady(6, 4);
        @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        // MEM_LAT=4: four-cycle window, data taken from the last cycle only.
        bus4.i_req = 1'b1;
        bus4.i_addr = 32'h40;
        bus4.mem_rdata = 32'h1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkBit("l4_en", bus4.mem_en, 1'b1);
            checkOutput("l4_addr", bus4.mem_addr, 32'h40);
            checkBit("l4_no_ready", bus4.i_ready, 1'b0);
            if (k == 2)
                checkOutput("l4_rdata_mid", bus4.i_rdata, 32'h0);
            if (k < 4)
                bus4.mem_rdata = 32'(k + 1);
        end
        @(negedge clk);
        checkBit("l4_ready", bus4.i_ready, 1'b1);
        checkBit("l4_en_off", bus4.mem_en, 1'b0);
        checkOutput("l4_rdata", bus4.i_rdata, 32'h4);
        bus4.i_req = 1'b0;
        @(negedge clk);
        checkBit("l4_ready_pulse", bus4.i_ready, 1'b0);

        // MEM_LAT=1: single-cycle window.
        bus1.i_req = 1'b1;
        bus1.i_addr = 32'h10;
        bus1.mem_rdata = 32'h77;
        @(negedge clk);
        checkBit("l1_en", bus1.mem_en, 1'b1);
        checkOutput("l1_addr", bus1.mem_addr, 32'h10);
        @(negedge clk);
        checkBit("l1_en_off", bus1.mem_en, 1'b0);
        checkBit("l1_ready", bus1.i_ready, 1'b1);
        checkOutput("l1_rdata", bus1.i_rdata, 32'h77);
        bus1.i_req = 1'b0;
        @(negedge clk);
        checkBit("l1_ready_pulse", bus1.i_ready, 1'b0);
        checkBit("l1_busy", bus1.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Sequencing controller and arbiter for the single-port backing data memory that sits behind the caches. It accepts refill requests from the instruction-cache side and refill/eviction requests from the two-way data cache. It runs each request as a fixed-latency memory access sequence: a dirty writeback first, then a line-word fetch. It returns the fetched word with a one-cycle ready pulse, and requesters stall while their request is pending.

## Interface
- MEM_LAT, 2: cycles each memory access is held (legal range 1–15); mem_rdata is valid in the last cycle of a read.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- i_req  in  1  I-side read request; held high until i_ready.
- i_addr  in  32  I-side read address.
- i_ready  out  1  one-cycle pulse: i_rdata valid, request complete.
- i_rdata  out  32  registered I-side read data.
- d_req  in  1  D-side request; held high until d_ready.
- d_wb  in  1  with d_req: perform writeback of d_wb_data to d_wb_addr before the fetch.
- d_wb_addr  in  32  eviction address.
- d_wb_data  in  32  eviction data.
- d_addr  in  32  D-side fetch address.
- d_ready  out  1  one-cycle pulse: d_rdata valid, request complete.
- d_rdata  out  32  registered D-side read data.
- mem_en  out  1  memory access active.
- mem_we  out  1  access is a write.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, I_RD, D_WB, D_RD, RESP.
- IDLE: one request only -> grant it. Both pending -> grant the side not granted last.
  - last_grant resets to I, so D wins the first tie.
- On grant, latch all request fields (addresses, wb data, d_wb) and the granted side.
  - Inputs are ignored until the next IDLE.
- Grant I -> I_RD. Grant D with d_wb=1 -> D_WB. Grant D with d_wb=0 -> D_RD.
- I_RD / D_RD: mem_en=1, mem_we=0, mem_addr = latched read address, held MEM_LAT cycles.
  - A 4-bit counter cnt counts 0..MEM_LAT-1.
  - At cnt==MEM_LAT-1, capture mem_rdata into i_rdata/d_rdata, clear cnt, go to RESP.
- D_WB: mem_en=1, mem_we=1, mem_addr = latched wb addr, mem_wdata = latched wb data, held MEM_LAT cycles.
  - At cnt==MEM_LAT-1, go directly to D_RD; mem_en stays high across the boundary.
- RESP: assert i_ready or d_ready for the granted side, one cycle only, then go to IDLE.
  - The requester must drop req in the cycle after ready. A req still high in IDLE is treated as a new request.
- mem_* and ready outputs are decoded from registered state and latches only; no combinational path from request inputs.
- mem_wdata=0 and mem_we=0 outside D_WB. mem_addr=0 in IDLE and RESP.
- rdata registers hold their value until the next capture for the same side.

## Timing
- Reset (async, rst low): state=IDLE, cnt=0, last_grant=I, all outputs 0.
  - An in-flight access is aborted immediately (mem_en falls without waiting for a clock); no ready is issued.
- Request latency, counting the first req-high edge as edge 0:
  - Plain read: grant at edge 0, access edges 1..MEM_LAT, ready in cycle MEM_LAT+1.
  - With writeback: ready in cycle 2*MEM_LAT+1.
- A new request arriving during busy waits. Its fields are sampled only at its grant edge.
- Throughput: one request per MEM_LAT+2 cycles (2*MEM_LAT+2 with writeback). The IDLE cycle is always present between requests.
- Requests arriving while both are pending alternate strictly (round-robin), so there is no starvation.
- Reset deasserting in the same cycle as req: the request is granted at the first clock edge after release.

## Test plan
- MEM_LAT=2, i_req with i_addr=0x100, memory returns 0xDEADBEEF -> mem_en high for 2 cycles at addr 0x100; i_ready pulses one cycle later with i_rdata=0xDEADBEEF; busy low afterwards.
- d_req, d_wb=1, d_wb_addr=0x200, d_wb_data=0x11, d_addr=0x300 -> 2 write cycles (mem_we=1, addr 0x200, wdata 0x11), then 2 read cycles at 0x300; d_ready pulses 5 cycles after grant.
- i_req and d_req asserted in the same cycle after reset -> D served first, then I; swap and repeat -> order alternates D, I, D, I.
- MEM_LAT=1 and MEM_LAT=4 builds -> access windows of 1 and 4 cycles; rdata captured only in the last cycle (bench changes mem_rdata mid-window to check).
- rst pulled low mid D_WB -> mem_en/mem_we drop without waiting for a clock, no d_ready; after release the held d_req restarts from D_WB.
- i_addr changed while the I request is being served -> mem_addr stays at the value latched at grant.
